// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control unit with memory handshakes, bus-timeout trap,
// HALT state and illegal-opcode trap. One instance per core, between the
// instruction register and the multicycle datapath.
// Optional feature: define MCU_PERF_CNT_EN to build the retired/cycles
// performance counters; otherwise both outputs are tied to zero.
module mc_ctrl_fsm #(
    parameter int OPW      = 6,
    parameter int ALUOPW   = 3,
    parameter int WAIT_MAX = 15,
    parameter int CNTW     = 32
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [OPW-1:0]    opcode,
    input  logic              zero,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              PCWre,
    output logic              IRWre,
    output logic              RegWre,
    output logic              ALUSrcB,
    output logic              ALUM2Reg,
    output logic              WrRegData,
    output logic              DataMemRW,
    output logic [1:0]        Extsel,
    output logic [ALUOPW-1:0] ALUOp,
    output logic [1:0]        PCSrc,
    output logic [1:0]        RegOut,
    output logic              halted,
    output logic              illegal,
    output logic              bus_err,
    output logic [CNTW-1:0]   retired,
    output logic [CNTW-1:0]   cycles
);

    // ISA opcodes, zero-extended to OPW.
    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010001);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(6'b011000);
    localparam logic [OPW-1:0] OP_MOVE = OPW'(6'b100000);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(6'b100111);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
    localparam logic [OPW-1:0] OP_JR   = OPW'(6'b111001);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b111010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

    // ALU function codes (3-bit, zero-extended onto ALUOp).
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    // Immediate extender modes.
    localparam logic [1:0] EXT_SA   = 2'b00;  // zero-extended shift amount
    localparam logic [1:0] EXT_ZERO = 2'b01;  // zero-extended immediate
    localparam logic [1:0] EXT_SIGN = 2'b10;  // sign-extended immediate

    // Destination register select.
    localparam logic [1:0] RD_RA = 2'b00;  // $31 (link)
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    // Next-PC select.
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    // Wait counter sized to hold WAIT_MAX; the trap fires on the not-ready
    // cycle that brings the count up to WAIT_MAX.
    localparam int WW          = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int WAIT_LAST_I = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LAST_I);

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EXE_R, S_EXE_BR, S_EXE_M, S_MEM, S_WB_R, S_WB_LW, S_HALT, S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_LW, C_SW, C_BEQ, C_J, C_JR, C_JAL, C_HALT, C_ILL
    } op_class_e;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       pc_wre;
        logic       ir_wre;
        logic       reg_wre;
        logic       alu_src_b;
        logic       alu_m2reg;
        logic       wr_reg_data;
        logic       data_mem_rw;
        logic [1:0] extsel;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic [1:0] reg_out;
    } ctrl_t;

    state_e          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;

    logic [OPW-1:0]  op_cur;
    op_class_e       op_class;
    logic [2:0]      dec_alu;
    logic            dec_src_b;
    logic [1:0]      dec_ext;
    logic [1:0]      dec_reg_out;
    logic            wait_expired;
    ctrl_t           ctrl_c;
    ctrl_t           ctrl_o;

    // Decode the active opcode into an instruction class and EXE_R datapath fields.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        op_cur      = (state_q == S_ID) ? opcode : op_q;
        op_class    = C_ILL;
        dec_alu     = ALU_ADD;
        dec_src_b   = 1'b0;
        dec_ext     = EXT_SA;
        dec_reg_out = RD_RA;
        case (op_cur)
            OP_ADD:  begin op_class = C_R; dec_reg_out = RD_RD; end
            OP_SUB:  begin op_class = C_R; dec_alu = ALU_SUB; dec_reg_out = RD_RD; end
            OP_ADDI: begin
                op_class = C_R; dec_src_b = 1'b1; dec_ext = EXT_SIGN; dec_reg_out = RD_RT;
            end
            OP_OR:   begin op_class = C_R; dec_alu = ALU_OR;  dec_reg_out = RD_RD; end
            OP_AND:  begin op_class = C_R; dec_alu = ALU_AND; dec_reg_out = RD_RD; end
            OP_ORI:  begin
                op_class = C_R; dec_alu = ALU_OR; dec_src_b = 1'b1;
                dec_ext = EXT_ZERO; dec_reg_out = RD_RT;
            end
            OP_SLL:  begin
                op_class = C_R; dec_alu = ALU_SLL; dec_src_b = 1'b1; dec_reg_out = RD_RD;
            end
            OP_MOVE: begin op_class = C_R; dec_reg_out = RD_RD; end
            OP_SLT:  begin op_class = C_R; dec_alu = ALU_SLT; dec_reg_out = RD_RD; end
            OP_LW:   op_class = C_LW;
            OP_SW:   op_class = C_SW;
            OP_BEQ:  op_class = C_BEQ;
            OP_J:    op_class = C_J;
            OP_JR:   op_class = C_JR;
            OP_JAL:  op_class = C_JAL;
            OP_HALT: op_class = C_HALT;
            default: op_class = C_ILL;
        endcase
    end

    // Next-state, wait counter, sticky trap causes and control strobes.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wait_cnt_d   = '0;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        ctrl_c       = '0;
        wait_expired = (WAIT_MAX != 0) && (wait_cnt_q == WAIT_LAST);

        // The counter only runs while stalled in IF or MEM, so any entry into
        // either state starts from zero.
        if ((state_q == S_IF && !imem_ready) || (state_q == S_MEM && !dmem_ready)) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end

        case (state_q)
            S_IF: begin
                ctrl_c.imem_req = 1'b1;
                ctrl_c.ir_wre   = imem_ready;
                if (imem_ready) begin
                    state_d = S_ID;
                end else if (wait_expired) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_ID: begin
                op_d = opcode;
                case (op_class)
                    C_R:          state_d = S_EXE_R;
                    C_LW, C_SW:   state_d = S_EXE_M;
                    C_BEQ:        state_d = S_EXE_BR;
                    C_HALT:       state_d = S_HALT;
                    C_J: begin
                        ctrl_c.pc_wre = 1'b1;
                        ctrl_c.pc_src = PC_J;
                        state_d       = S_IF;
                    end
                    C_JR: begin
                        ctrl_c.pc_wre = 1'b1;
                        ctrl_c.pc_src = PC_JR;
                        state_d       = S_IF;
                    end
                    C_JAL: begin
                        ctrl_c.pc_wre      = 1'b1;
                        ctrl_c.pc_src      = PC_J;
                        ctrl_c.reg_wre     = 1'b1;
                        ctrl_c.wr_reg_data = 1'b0;
                        ctrl_c.reg_out     = RD_RA;
                        state_d            = S_IF;
                    end
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXE_R: begin
                ctrl_c.alu_op    = dec_alu;
                ctrl_c.alu_src_b = dec_src_b;
                ctrl_c.extsel    = dec_ext;
                ctrl_c.reg_out   = dec_reg_out;
                state_d          = S_WB_R;
            end
            S_WB_R: begin
                ctrl_c.reg_wre     = 1'b1;
                ctrl_c.wr_reg_data = 1'b1;
                ctrl_c.pc_wre      = 1'b1;
                ctrl_c.pc_src      = PC_SEQ;
                state_d            = S_IF;
            end
            S_EXE_BR: begin
                ctrl_c.alu_op = ALU_SUB;
                ctrl_c.extsel = EXT_SIGN;
                ctrl_c.pc_wre = 1'b1;
                ctrl_c.pc_src = zero ? PC_BR : PC_SEQ;
                state_d       = S_IF;
            end
            S_EXE_M: begin
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.alu_src_b = 1'b1;
                ctrl_c.extsel    = EXT_SIGN;
                state_d          = S_MEM;
            end
            S_MEM: begin
                ctrl_c.dmem_req    = 1'b1;
                ctrl_c.data_mem_rw = (op_class == C_SW);
                if (dmem_ready) begin
                    if (op_class == C_SW) begin
                        ctrl_c.pc_wre = 1'b1;
                        state_d       = S_IF;
                    end else begin
                        state_d = S_WB_LW;
                    end
                end else if (wait_expired) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_WB_LW: begin
                ctrl_c.reg_wre   = 1'b1;
                ctrl_c.alu_m2reg = 1'b1;
                ctrl_c.reg_out   = RD_RT;
                ctrl_c.pc_wre    = 1'b1;
                state_d          = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    // State, captured opcode, wait counter and sticky trap causes.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q    <= S_IF;
            op_q       <= '0;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Force every strobe low while reset is asserted, whatever the state register holds.
    always_comb begin
        ctrl_o = RST ? '0 : ctrl_c;
    end

    assign imem_req  = ctrl_o.imem_req;
    assign dmem_req  = ctrl_o.dmem_req;
    assign PCWre     = ctrl_o.pc_wre;
    assign IRWre     = ctrl_o.ir_wre;
    assign RegWre    = ctrl_o.reg_wre;
    assign ALUSrcB   = ctrl_o.alu_src_b;
    assign ALUM2Reg  = ctrl_o.alu_m2reg;
    assign WrRegData = ctrl_o.wr_reg_data;
    assign DataMemRW = ctrl_o.data_mem_rw;
    assign Extsel    = ctrl_o.extsel;
    assign ALUOp     = ALUOPW'(ctrl_o.alu_op);
    assign PCSrc     = ctrl_o.pc_src;
    assign RegOut    = ctrl_o.reg_out;
    assign halted    = !RST && (state_q == S_HALT);
    assign illegal   = !RST && illegal_q;
    assign bus_err   = !RST && bus_err_q;

`ifdef MCU_PERF_CNT_EN
    logic [CNTW-1:0] retired_q, retired_d;
    logic [CNTW-1:0] cycles_q, cycles_d;

    // Count retirements (one PCWre per instruction) and live cycles outside HALT/TRAP.
    always_comb begin
        retired_d = retired_q + CNTW'(ctrl_c.pc_wre);
        cycles_d  = cycles_q;
        if (state_q != S_HALT && state_q != S_TRAP) begin
            cycles_d = cycles_q + CNTW'(1);
        end
    end

    // Counter registers, cleared by reset and wrapping naturally.
    always_ff @(posedge clk) begin
        if (RST) begin
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            retired_q <= retired_d;
            cycles_q  <= cycles_d;
        end
    end

    assign retired = RST ? '0 : retired_q;
    assign cycles  = RST ? '0 : cycles_q;
`else
    assign retired = '0;
    assign cycles  = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed scoreboard bench for mc_ctrl_fsm. The driver pushes the
// hand-computed control vector for each cycle; the monitor pops and compares on
// the falling edge.
module tb_mc_ctrl_fsm;

    localparam int OPW = 6, ALUOPW = 3, WAIT_MAX = 15, CNTW = 32;

    localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010010, OP_SLL  = 6'b011000, OP_SLT  = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000, OP_LW   = 6'b110001, OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000, OP_JR   = 6'b111001, OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111, OP_BAD  = 6'b101010;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       pcwre;
        logic       irwre;
        logic       regwre;
        logic       alusrcb;
        logic       alum2reg;
        logic       wrregdata;
        logic       datamemrw;
        logic [1:0] extsel;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic [1:0] regout;
        logic       halted;
        logic       illegal;
        logic       bus_err;
    } ctrl_t;

    logic              clk = 1'b1;
    logic              RST = 1'b1;
    logic [OPW-1:0]    opcode = OP_BAD;
    logic              zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic              imem_req, dmem_req, PCWre, IRWre, RegWre, ALUSrcB, ALUM2Reg;
    logic              WrRegData, DataMemRW, halted, illegal, bus_err;
    logic [1:0]        Extsel, PCSrc, RegOut;
    logic [ALUOPW-1:0] ALUOp;
    logic [CNTW-1:0]   retired, cycles;

    mc_ctrl_fsm #(.OPW(OPW), .ALUOPW(ALUOPW), .WAIT_MAX(WAIT_MAX), .CNTW(CNTW)) dut (
        .clk(clk), .RST(RST), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .PCWre(PCWre), .IRWre(IRWre),
        .RegWre(RegWre), .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg), .WrRegData(WrRegData),
        .DataMemRW(DataMemRW), .Extsel(Extsel), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .RegOut(RegOut), .halted(halted), .illegal(illegal), .bus_err(bus_err),
        .retired(retired), .cycles(cycles)
    );

    always #5 clk = ~clk;

    ctrl_t act;
    assign act = {imem_req, dmem_req, PCWre, IRWre, RegWre, ALUSrcB, ALUM2Reg, WrRegData,
                  DataMemRW, Extsel, ALUOp[2:0], PCSrc, RegOut, halted, illegal, bus_err};

    ctrl_t        q_exp[$];
    string        q_name[$];
    logic [63:0]  q_cnt[$];
    int           n_checks = 0;
    int           n_errors = 0;
    logic [31:0]  exp_retired = '0;
    logic [31:0]  exp_cycles  = '0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Expected-vector constructors for each control state.
    function automatic ctrl_t c_if(input logic ir);
        ctrl_t c = '0; c.imem_req = 1'b1; c.irwre = ir; return c;
    endfunction
    function automatic ctrl_t c_exe(input logic [2:0] alu, input logic sb,
                                    input logic [1:0] ext, input logic [1:0] ro);
        ctrl_t c = '0; c.aluop = alu; c.alusrcb = sb; c.extsel = ext; c.regout = ro; return c;
    endfunction
    function automatic ctrl_t c_wbr();
        ctrl_t c = '0; c.regwre = 1'b1; c.wrregdata = 1'b1; c.pcwre = 1'b1; return c;
    endfunction
    function automatic ctrl_t c_br(input logic z);
        ctrl_t c = '0; c.aluop = 3'b001; c.extsel = 2'b10; c.pcwre = 1'b1;
        c.pcsrc = z ? 2'b01 : 2'b00; return c;
    endfunction
    function automatic ctrl_t c_exem();
        ctrl_t c = '0; c.alusrcb = 1'b1; c.extsel = 2'b10; return c;
    endfunction
    function automatic ctrl_t c_mem(input logic is_sw, input logic dr);
        ctrl_t c = '0; c.dmem_req = 1'b1; c.datamemrw = is_sw; c.pcwre = is_sw & dr; return c;
    endfunction
    function automatic ctrl_t c_wblw();
        ctrl_t c = '0; c.regwre = 1'b1; c.alum2reg = 1'b1; c.regout = 2'b01; c.pcwre = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_jmp(input logic [1:0] src, input logic link);
        ctrl_t c = '0; c.pcwre = 1'b1; c.pcsrc = src; c.regwre = link; return c;
    endfunction
    function automatic ctrl_t c_halt();
        ctrl_t c = '0; c.halted = 1'b1; return c;
    endfunction
    function automatic ctrl_t c_trap(input logic ill, input logic be);
        ctrl_t c = '0; c.illegal = ill; c.bus_err = be; return c;
    endfunction

    // Drive one cycle of inputs and queue the response expected in that cycle.
    task automatic step(input string nm, input logic rst, input logic [5:0] op, input logic z,
                        input logic ir, input logic dr, input ctrl_t e);
        RST = rst; opcode = op; zero = z; imem_ready = ir; dmem_ready = dr;
        q_exp.push_back(e);
        q_name.push_back(nm);
        q_cnt.push_back(rst ? 64'd0 : {exp_retired, exp_cycles});
`ifdef MCU_PERF_CNT_EN
        if (rst) begin
            exp_retired = '0;
            exp_cycles  = '0;
        end else begin
            if (e.pcwre) exp_retired = exp_retired + 1;
            if (!(e.halted || e.illegal || e.bus_err)) exp_cycles = exp_cycles + 1;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string nm, input int waits);
        for (int i = 0; i < waits; i++) step({nm, " IF wait"}, 0, OP_BAD, 0, 0, 1, c_if(0));
        step({nm, " IF"}, 0, OP_BAD, 0, 1, 1, c_if(1));
    endtask

    task automatic run_r(input string nm, input logic [5:0] op, input logic [2:0] alu,
                         input logic sb, input logic [1:0] ext, input logic [1:0] ro);
        fetch(nm, 0);
        step({nm, " ID"}, 0, op, 0, 1, 1, '0);
        step({nm, " EXE_R"}, 0, OP_BAD, 0, 1, 1, c_exe(alu, sb, ext, ro));
        step({nm, " WB_R"}, 0, OP_BAD, 0, 1, 1, c_wbr());
    endtask

    task automatic do_reset(input string nm, input int n);
        for (int i = 0; i < n; i++) step({nm, " reset"}, 1, OP_BAD, 0, 1, 1, '0);
    endtask

    // Monitor: compare the DUT outputs against the queued expectation each falling edge.
    initial begin
        ctrl_t       e;
        string       nm;
        logic [63:0] cnt;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e   = q_exp.pop_front();
                nm  = q_name.pop_front();
                cnt = q_cnt.pop_front();
                check(nm, 64'(act), 64'(e));
                check({nm, " counters"}, {retired, cycles}, cnt);
            end
        end
    end

    // Directed stimulus.
    initial begin
        do_reset("init", 3);

        // add: zero-wait 4-cycle R-type
        run_r("add", OP_ADD, 3'b000, 1'b0, 2'b00, 2'b10);

        // beq taken and not taken
        fetch("beq1", 0);
        step("beq1 ID", 0, OP_BEQ, 1, 1, 1, '0);
        step("beq1 EXE_BR", 0, OP_BAD, 1, 1, 1, c_br(1));
        fetch("beq0", 0);
        step("beq0 ID", 0, OP_BEQ, 0, 1, 1, '0);
        step("beq0 EXE_BR", 0, OP_BAD, 0, 1, 1, c_br(0));

        // lw with three not-ready MEM cycles
        fetch("lw", 0);
        step("lw ID", 0, OP_LW, 0, 1, 1, '0);
        step("lw EXE_M", 0, OP_BAD, 0, 1, 1, c_exem());
        for (int i = 0; i < 3; i++) step("lw MEM wait", 0, OP_BAD, 0, 1, 0, c_mem(0, 0));
        step("lw MEM", 0, OP_BAD, 0, 1, 1, c_mem(0, 1));
        step("lw WB_LW", 0, OP_BAD, 0, 1, 1, c_wblw());

        // sw zero-wait
        fetch("sw", 0);
        step("sw ID", 0, OP_SW, 0, 1, 1, '0);
        step("sw EXE_M", 0, OP_BAD, 0, 1, 1, c_exem());
        step("sw MEM", 0, OP_BAD, 0, 1, 1, c_mem(1, 1));

        // jumps
        fetch("j", 0);
        step("j ID", 0, OP_J, 0, 1, 1, c_jmp(2'b11, 0));
        fetch("jr", 0);
        step("jr ID", 0, OP_JR, 0, 1, 1, c_jmp(2'b10, 0));
        fetch("jal", 0);
        step("jal ID", 0, OP_JAL, 0, 1, 1, c_jmp(2'b11, 1));

        // other R/ALU encodings
        run_r("sub",  OP_SUB,  3'b001, 1'b0, 2'b00, 2'b10);
        run_r("addi", OP_ADDI, 3'b000, 1'b1, 2'b10, 2'b01);
        run_r("ori",  OP_ORI,  3'b011, 1'b1, 2'b01, 2'b01);
        run_r("sll",  OP_SLL,  3'b010, 1'b1, 2'b00, 2'b10);
        run_r("slt",  OP_SLT,  3'b110, 1'b0, 2'b00, 2'b10);

        // ready on the last allowed wait cycle wins over the timeout
        fetch("edge", 14);
        step("edge ID", 0, OP_J, 0, 1, 1, c_jmp(2'b11, 0));

        // imem_ready held low: 15 wait cycles then bus-error trap, sticky
        for (int i = 0; i < 15; i++) step("tmo IF wait", 0, OP_BAD, 0, 0, 1, c_if(0));
        step("tmo TRAP", 0, OP_BAD, 0, 0, 1, c_trap(0, 1));
        step("tmo TRAP sticky", 0, OP_BAD, 0, 1, 1, c_trap(0, 1));
        do_reset("tmo", 1);

        // illegal opcode: trap without a PCWre
        fetch("ill", 0);
        step("ill ID", 0, OP_BAD, 0, 1, 1, '0);
        step("ill TRAP", 0, OP_BAD, 0, 1, 1, c_trap(1, 0));
        step("ill TRAP sticky", 0, OP_BAD, 0, 1, 1, c_trap(1, 0));
        do_reset("ill", 1);

        // halt holds until reset
        fetch("halt", 0);
        step("halt ID", 0, OP_HALT, 0, 1, 1, '0);
        for (int i = 0; i < 3; i++) step("halt HALT", 0, OP_BAD, 0, 1, 1, c_halt());
        do_reset("halt", 2);

        // reset in the middle of MEM with dmem_req high
        fetch("rmem", 0);
        step("rmem ID", 0, OP_LW, 0, 1, 1, '0);
        step("rmem EXE_M", 0, OP_BAD, 0, 1, 1, c_exem());
        step("rmem MEM wait", 0, OP_BAD, 0, 1, 0, c_mem(0, 0));
        step("rmem reset", 1, OP_BAD, 0, 1, 0, '0);
        fetch("post", 0);
        step("post ID", 0, OP_JR, 0, 1, 1, c_jmp(2'b10, 0));
        step("post IF", 0, OP_BAD, 0, 0, 1, c_if(0));

        // let the monitor drain, bounded
        for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard drain", 64'(q_exp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multicycle control unit, successor to the fixed-width 3-bit-state controller. Drives the same datapath control strobes (PC, IR, register file, ALU, data memory) but adds ready/request handshakes to instruction and data memory, a bus-timeout trap, a true HALT state, and illegal-opcode trapping. It sits between the instruction register and the multicycle datapath, one instance per core.

## Interface
- OPW, 6, opcode width; opcode encodings are the team ISA table values zero-extended to OPW.
- ALUOPW, 3, ALUOp width, ≥3; ALU codes are zero-extended.
- WAIT_MAX, 15, max wait cycles on a memory handshake before a bus-error trap; 0 disables the timeout.
- CNTW, 32, performance counter width.

- clk  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- opcode  in  OPW  IR opcode field, valid from ID onward.
- zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- imem_req / dmem_req  out  1  memory request strobes.
- PCWre, IRWre, RegWre, ALUSrcB, ALUM2Reg, WrRegData, DataMemRW  out  1 each  datapath controls.
- Extsel  out  2; ALUOp  out  ALUOPW; PCSrc  out  2; RegOut  out  2.
- halted, illegal, bus_err  out  1  sticky status.
- retired, cycles  out  CNTW  performance counters.

## Operation
- States: IF, ID, EXE_R, EXE_BR, EXE_M, MEM, WB_R, WB_LW, HALT, TRAP. Held in a registered state; op_q captured at ID exit.
- Outputs are decoded from state and op_cur. op_cur = opcode in ID, op_q otherwise. Any control not named for a state is 0.
- IF: imem_req=1, IRWre=imem_ready. Go to ID on imem_ready.
- ID: decode. Invalid encodings go to TRAP.
  - R/ALU ops (add, sub, addi, or, and, ori, sll, move, slt) → EXE_R.
  - lw/sw → EXE_M; beq → EXE_BR; halt → HALT.
  - j: PCWre=1, PCSrc=11 → IF. jr: PCWre=1, PCSrc=10 → IF.
  - jal: PCWre=1, PCSrc=11, RegWre=1, WrRegData=0, RegOut=00 → IF.
- EXE_R: ALUOp, ALUSrcB, Extsel, RegOut per ISA table → WB_R.
- WB_R: RegWre=1, WrRegData=1, PCWre=1, PCSrc=00 → IF.
- EXE_BR: ALUOp=001, ALUSrcB=0, Extsel=10, PCWre=1, PCSrc = zero ? 01 : 00 → IF.
- EXE_M: ALUOp=000, ALUSrcB=1, Extsel=10 → MEM.
- MEM: dmem_req=1; DataMemRW=1 held for sw, 0 for lw.
  - On dmem_ready: sw → IF with PCWre=1; lw → WB_LW.
- WB_LW: RegWre=1, ALUM2Reg=1, RegOut=01, PCWre=1 → IF.
- HALT: halted=1, all strobes 0. Remain until RST.
- TRAP: illegal=1 (bad opcode) or bus_err=1 (timeout). All strobes 0. Remain until RST.
- Timeout: wait counter clears on entering IF/MEM and counts each not-ready cycle. When it reaches WAIT_MAX with ready still low → TRAP, bus_err=1. Ready arriving in the same cycle as the limit wins.

## Timing
- Reset: while RST=1, every output is 0 and counters are 0. The next state is IF, entered on the first edge with RST=0, regardless of the current state (including mid-MEM with dmem_req high).
- Zero-wait latencies (cycles per instruction):
  - j/jr/jal: 2
  - beq: 3
  - R/ALU ops: 4
  - sw: 4
  - lw: 5
- Each not-ready cycle in IF or MEM adds one cycle.
- PCWre is 1 for exactly one cycle per retired instruction.
- IRWre is 1 only when both IF and imem_ready hold.

## Configuration
- MCU_PERF_CNT_EN defined:
  - cycles increments every non-reset cycle outside HALT/TRAP.
  - retired increments on each cycle with PCWre=1.
  - Both wrap modulo 2^CNTW.
- MCU_PERF_CNT_EN undefined: counter logic is omitted and retired/cycles are tied to 0.

## Test plan
- Reset with RST=1 for 3 cycles: all outputs 0. First cycle after release: state IF, imem_req=1.
- add, ready always 1: IF,ID,EXE_R,WB_R. RegWre=1 and PCWre=1 only in cycle 4; ALUOp=000, RegOut=10.
- beq with zero=1: PCSrc=01, PCWre=1 in cycle 3. Repeat with zero=0: PCSrc=00.
- lw with dmem_ready low 3 cycles: MEM lasts 4 cycles with dmem_req=1, DataMemRW=0; WB_LW in cycle 8 with ALUM2Reg=1.
- WAIT_MAX=15, imem_ready held 0: TRAP entered after 15 wait cycles, bus_err=1 sticky. RST returns to IF.
- Opcode 6'b101010: TRAP, illegal=1, no PCWre. With MCU_PERF_CNT_EN, retired does not increment.
